// File: rtl/pid_sched_pkg.sv
// Shared FSM encoding and channel-id width helper for the PID channel scheduler.
package pid_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ROUTE = 2'd3
   } state_e;

   function automatic int cid_width(input int n_chan);
      return (n_chan > 2) ? $clog2(n_chan) : 1;
   endfunction

endpackage

// File: rtl/pid_rr_arbiter.sv
// Circular-priority pick: first requesting channel strictly after last_i, wrapping.
module pid_rr_arbiter
   import pid_sched_pkg::*;
#(
   parameter int N_CHAN = 8,
   parameter int W_CID  = cid_width(N_CHAN)
) (
   input  logic [N_CHAN-1:0] req_i,
   input  logic [W_CID-1:0]  last_i,
   output logic              any_o,
   output logic [W_CID-1:0]  grant_o
);

   always_comb begin
      int idx;
      idx     = 0;
      any_o   = 1'b0;
      grant_o = '0;
      // k = N_CHAN lands back on last_i, so it is only chosen when it is the sole requester
      for (int k = 1; k <= N_CHAN; k++) begin
         idx = (int'(last_i) + k) % N_CHAN;
         if (!any_o && req_i[idx]) begin
            any_o   = 1'b1;
            grant_o = W_CID'(idx);
         end
      end
   end

endmodule

// File: rtl/pid_channel_scheduler.sv
// Round-robin scheduler sharing one PID core among N_CHAN sampled channels, one transaction in flight.
// Optional WAIT watchdog is enabled by defining PID_SCHED_TIMEOUT_EN.
module pid_channel_scheduler
   import pid_sched_pkg::*;
#(
   parameter int  N_CHAN         = 8,
   parameter int  W_DATA         = 18,
   parameter int  TIMEOUT_CYCLES = 64,
   localparam int W_CID          = cid_width(N_CHAN)
) (
   input  logic                       clk_in,
   input  logic                       reset_n_in,
   input  logic [N_CHAN*W_DATA-1:0]   chan_data_in,
   input  logic [N_CHAN-1:0]          chan_valid_in,
   input  logic [N_CHAN-1:0]          chan_en_in,
   input  logic                       clear_in,
   output logic [W_DATA-1:0]          core_data_out,
   output logic [W_CID-1:0]           core_chan_out,
   output logic                       core_valid_out,
   input  logic [W_DATA-1:0]          core_data_in,
   input  logic                       core_valid_in,
   output logic [W_DATA-1:0]          result_data_out,
   output logic [W_CID-1:0]           result_chan_out,
   output logic                       result_valid_out,
   output logic [N_CHAN-1:0]          overrun_out,
   output logic                       timeout_out
);

   localparam int W_TO = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_e             state_q, state_d;
   logic [N_CHAN-1:0]  pending_q, pending_d;
   logic [N_CHAN-1:0]  overrun_q, overrun_d;
   logic [W_DATA-1:0]  buf_q [N_CHAN];
   logic [W_DATA-1:0]  buf_d [N_CHAN];
   logic [W_CID-1:0]   grant_q, grant_d;
   logic [W_CID-1:0]   last_grant_q, last_grant_d;
   logic [W_DATA-1:0]  result_q, result_d;
   logic [W_TO-1:0]    wait_cnt_q, wait_cnt_d;
   logic [N_CHAN-1:0]  issue_sel;
   logic               arb_any;
   logic [W_CID-1:0]   arb_grant;
   logic               timeout_hit;

   pid_rr_arbiter #(
      .N_CHAN (N_CHAN),
      .W_CID  (W_CID)
   ) u_arb (
      .req_i   (pending_q),
      .last_i  (last_grant_q),
      .any_o   (arb_any),
      .grant_o (arb_grant)
   );

   assign issue_sel = (state_q == ST_ISSUE) ? (N_CHAN'(1) << grant_q) : '0;

   // A capture landing on its own issue cycle re-arms pending without counting as an overrun.
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      buf_d     = buf_q;
      for (int i = 0; i < N_CHAN; i++) begin
         if (clear_in) begin
            pending_d[i] = 1'b0;
            overrun_d[i] = 1'b0;
         end else if (!chan_en_in[i]) begin
            pending_d[i] = 1'b0;
         end else if (chan_valid_in[i]) begin
            buf_d[i] = chan_data_in[i*W_DATA +: W_DATA];
            if (pending_q[i] && !issue_sel[i]) begin
               overrun_d[i] = 1'b1;
            end
            pending_d[i] = 1'b1;
         end else if (issue_sel[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

`ifdef PID_SCHED_TIMEOUT_EN
   assign timeout_hit = (state_q == ST_WAIT) && !core_valid_in &&
                        (wait_cnt_q == W_TO'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif
   assign timeout_out = timeout_hit;
   assign overrun_out = overrun_q;

   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      last_grant_d     = last_grant_q;
      result_d         = result_q;
      wait_cnt_d       = wait_cnt_q;
      core_valid_out   = 1'b0;
      core_data_out    = '0;
      core_chan_out    = '0;
      result_valid_out = 1'b0;
      result_data_out  = '0;
      result_chan_out  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_d = arb_grant;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_valid_out = 1'b1;
            core_data_out  = buf_q[grant_q];
            core_chan_out  = grant_q;
            last_grant_d   = grant_q;
            wait_cnt_d     = '0;
            state_d        = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_valid_in) begin
               result_d = core_data_in;
               state_d  = ST_ROUTE;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_ROUTE: begin
            result_valid_out = 1'b1;
            result_data_out  = result_q;
            result_chan_out  = grant_q;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         overrun_q    <= '0;
         grant_q      <= '0;
         last_grant_q <= W_CID'(N_CHAN - 1);
         result_q     <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         result_q     <= result_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   // Sample buffers are only read through gated outputs, so they need no reset.
   always_ff @(posedge clk_in) begin
      buf_q <= buf_d;
   end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Scoreboard bench for pid_channel_scheduler: directed captures, echoing core model, queued expectations.
module tb_pid_channel_scheduler;

   localparam int N  = 8;
   localparam int W  = 18;
   localparam int WC = 3;
`ifdef PID_SCHED_TIMEOUT_EN
   localparam int STALL = 20;
`else
   localparam int STALL = 70;
`endif

   typedef struct {
      int           chan;
      logic [W-1:0] data;
      int           cyc;
   } exp_t;

   logic            clk_in;
   logic            reset_n_in;
   logic [N*W-1:0]  chan_data_in;
   logic [N-1:0]    chan_valid_in;
   logic [N-1:0]    chan_en_in;
   logic            clear_in;
   logic [W-1:0]    core_data_out;
   logic [WC-1:0]   core_chan_out;
   logic            core_valid_out;
   logic [W-1:0]    core_data_in;
   logic            core_valid_in;
   logic [W-1:0]    result_data_out;
   logic [WC-1:0]   result_chan_out;
   logic            result_valid_out;
   logic [N-1:0]    overrun_out;
   logic            timeout_out;

   exp_t iss_q[$];
   exp_t res_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_issue = 0;
   int   n_res = 0;
   int   n_to = 0;
   int   to_cyc = -1;
   int   core_delay;
   logic core_hold;
   logic [W-1:0] rsp_dat;

   pid_channel_scheduler #(
      .N_CHAN(N), .W_DATA(W), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in),
      .chan_data_in(chan_data_in), .chan_valid_in(chan_valid_in), .chan_en_in(chan_en_in),
      .clear_in(clear_in),
      .core_data_out(core_data_out), .core_chan_out(core_chan_out), .core_valid_out(core_valid_out),
      .core_data_in(core_data_in), .core_valid_in(core_valid_in),
      .result_data_out(result_data_out), .result_chan_out(result_chan_out),
      .result_valid_out(result_valid_out),
      .overrun_out(overrun_out), .timeout_out(timeout_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(posedge clk_in) cyc <= cyc + 1;

   // Core model: echoes the issued sample after core_delay cycles, stalls while core_hold is set.
   initial begin
      core_valid_in = 1'b0;
      core_data_in  = '0;
      forever begin
         @(negedge clk_in);
         if (core_valid_out && reset_n_in) begin
            rsp_dat = core_data_out;
            repeat (core_delay) @(posedge clk_in);
            while (core_hold) @(posedge clk_in);
            #1;
            core_valid_in = 1'b1;
            core_data_in  = rsp_dat;
            @(posedge clk_in);
            #1;
            core_valid_in = 1'b0;
            core_data_in  = '0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic set_ch(input int ch, input logic [W-1:0] d);
      chan_data_in[ch*W +: W] = d;
      chan_valid_in[ch]       = 1'b1;
   endtask

   task automatic exp_txn(input int ch, input logic [W-1:0] d, input int icyc, input int rcyc);
      iss_q.push_back('{chan: ch, data: d, cyc: icyc});
      res_q.push_back('{chan: ch, data: d, cyc: rcyc});
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((iss_q.size() != 0 || res_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (iss_q.size() != 0 || res_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout outstanding issue=%0d result=%0d required 0", iss_q.size(), res_q.size());
         iss_q.delete();
         res_q.delete();
      end
      repeat (3) tick();
   endtask

   initial begin
      int   k;
      int   base;
      logic [W-1:0] v;
      reset_n_in    = 1'b0;
      chan_data_in  = '0;
      chan_valid_in = '0;
      chan_en_in    = '1;
      clear_in      = 1'b0;
      core_hold     = 1'b0;
      core_delay    = 1;

      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk_in);
               if (reset_n_in) begin
                  if (core_valid_out) begin
                     n_issue++;
                     checks++;
                     if (iss_q.size() == 0) begin
                        errors++;
                        $display("FAIL issue_unexpected chan=%0d data=%05h cyc=%0d required none",
                                 core_chan_out, core_data_out, cyc);
                     end else begin
                        e = iss_q.pop_front();
                        if (int'(core_chan_out) != e.chan || core_data_out !== e.data ||
                            (e.cyc >= 0 && cyc != e.cyc)) begin
                           errors++;
                           $display("FAIL issue chan=%0d data=%05h cyc=%0d required chan=%0d data=%05h cyc=%0d",
                                    core_chan_out, core_data_out, cyc, e.chan, e.data, e.cyc);
                        end
                     end
                  end
                  if (result_valid_out) begin
                     n_res++;
                     checks++;
                     if (res_q.size() == 0) begin
                        errors++;
                        $display("FAIL result_unexpected chan=%0d data=%05h cyc=%0d required none",
                                 result_chan_out, result_data_out, cyc);
                     end else begin
                        e = res_q.pop_front();
                        if (int'(result_chan_out) != e.chan || result_data_out !== e.data ||
                            (e.cyc >= 0 && cyc != e.cyc)) begin
                           errors++;
                           $display("FAIL result chan=%0d data=%05h cyc=%0d required chan=%0d data=%05h cyc=%0d",
                                    result_chan_out, result_data_out, cyc, e.chan, e.data, e.cyc);
                        end
                     end
                  end
                  if (timeout_out) begin
                     n_to++;
                     to_cyc = cyc;
                  end
               end
            end
         end
      join_none

      #2;
      chk("rst_core_valid", 64'(core_valid_out), 64'd0);
      chk("rst_result_valid", 64'(result_valid_out), 64'd0);
      chk("rst_overrun", 64'(overrun_out), 64'd0);
      chk("rst_ids_data", 64'({core_chan_out, result_chan_out, core_data_out, result_data_out, timeout_out}), 64'd0);
      repeat (3) @(posedge clk_in);
      #1 reset_n_in = 1'b1;
      repeat (2) tick();

      // Fairness: all channels at once from reset, then a refill wraps back to ch0.
      for (int i = 0; i < N; i++) begin
         v = W'(i) * 18'h01111 + 18'h000a0;
         set_ch(i, v);
         exp_txn(i, v, -1, -1);
      end
      tick();
      chan_valid_in = '0;
      drain(200);
      set_ch(5, 18'h15555);
      set_ch(0, 18'h10000);
      exp_txn(0, 18'h10000, -1, -1);
      exp_txn(5, 18'h15555, -1, -1);
      tick();
      chan_valid_in = '0;
      drain(60);

      // Single sample with a slow core: issue at +2, result one cycle after the core strobe.
      core_delay = 5;
      k = cyc;
      set_ch(3, 18'h00100);
      exp_txn(3, 18'h00100, k + 2, k + 8);
      tick();
      chan_valid_in = '0;
      drain(60);
      core_delay = 1;

      // Last grant is 3: ch6 must win over ch1.
      set_ch(1, 18'h21111);
      set_ch(6, 18'h26666);
      exp_txn(6, 18'h26666, -1, -1);
      exp_txn(1, 18'h21111, -1, -1);
      tick();
      chan_valid_in = '0;
      drain(60);

      // Overrun on ch1 and enable-drop on ch6 while the core is stalled on ch4.
      core_hold = 1'b1;
      set_ch(4, 18'h00444);
      exp_txn(4, 18'h00444, -1, -1);
      tick();
      chan_valid_in = '0;
      repeat (4) tick();
      set_ch(1, 18'h0aaaa);
      tick();
      set_ch(1, 18'h0bbbb);
      tick();
      chan_valid_in = '0;
      chk("overrun_set", 64'(overrun_out), 64'h02);
      exp_txn(1, 18'h0bbbb, -1, -1);
      set_ch(6, 18'h06666);
      tick();
      chan_valid_in = '0;
      chan_en_in[6] = 1'b0;
      set_ch(6, 18'h07777);
      tick();
      chan_valid_in = '0;
      chan_en_in[6] = 1'b1;
      chk("overrun_en_low", 64'(overrun_out), 64'h02);
      core_hold = 1'b0;
      drain(60);
      chk("overrun_sticky", 64'(overrun_out), 64'h02);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      chk("overrun_clear", 64'(overrun_out), 64'h00);

      // Clear wins over a simultaneous capture.
      base = n_issue;
      clear_in = 1'b1;
      set_ch(3, 18'h03333);
      tick();
      clear_in = 1'b0;
      chan_valid_in = '0;
      repeat (6) tick();
      chk("clear_beats_capture", 64'(n_issue - base), 64'd0);

      // Capture on ch2's own issue cycle re-arms it without overrun.
      k = cyc;
      set_ch(2, 18'h0c0de);
      exp_txn(2, 18'h0c0de, k + 2, -1);
      tick();
      chan_valid_in = '0;
      tick();
      set_ch(2, 18'h0beef);
      exp_txn(2, 18'h0beef, k + 6, -1);
      tick();
      chan_valid_in = '0;
      chk("issue_collision_no_overrun", 64'(overrun_out), 64'h00);
      drain(60);

`ifdef PID_SCHED_TIMEOUT_EN
      // Silent core: one timeout pulse 64 cycles into WAIT, late answer dropped.
      core_hold = 1'b1;
      base = n_to;
      k = cyc;
      set_ch(1, 18'h2abcd);
      iss_q.push_back('{chan: 1, data: 18'h2abcd, cyc: k + 2});
      tick();
      chan_valid_in = '0;
      for (int n = 0; n < 100 && n_to == base; n++) tick();
      chk("timeout_cycle", 64'(to_cyc), 64'(k + 66));
      repeat (4) tick();
      chk("timeout_once", 64'(n_to - base), 64'd1);
      base = n_res;
      core_hold = 1'b0;
      repeat (6) tick();
      chk("timeout_late_core_ignored", 64'(n_res - base), 64'd0);
      set_ch(2, 18'h12345);
      exp_txn(2, 18'h12345, -1, -1);
      tick();
      chan_valid_in = '0;
      drain(60);
`endif

      // Async reset mid-WAIT with an overrun flagged; first grant after release is ch0.
      core_hold = 1'b1;
      set_ch(2, 18'h02222);
      iss_q.push_back('{chan: 2, data: 18'h02222, cyc: -1});
      tick();
      chan_valid_in = '0;
      repeat (3) tick();
      set_ch(5, 18'h05555);
      tick();
      set_ch(5, 18'h05556);
      tick();
      chan_valid_in = '0;
      chk("pre_reset_overrun", 64'(overrun_out), 64'h20);
      repeat (STALL) tick();
`ifndef PID_SCHED_TIMEOUT_EN
      chk("no_timeout_when_disabled", 64'(n_to), 64'd0);
`endif
      base = n_res;
      #3 reset_n_in = 1'b0;
      #1;
      chk("async_reset_overrun", 64'(overrun_out), 64'd0);
      chk("async_reset_strobes", 64'({core_valid_out, result_valid_out, timeout_out, core_chan_out, result_chan_out}), 64'd0);
      repeat (2) tick();
      reset_n_in = 1'b1;
      core_hold = 1'b0;
      repeat (6) tick();
      chk("reset_late_core_ignored", 64'(n_res - base), 64'd0);
      set_ch(7, 18'h07070);
      set_ch(0, 18'h00f0f);
      exp_txn(0, 18'h00f0f, -1, -1);
      exp_txn(7, 18'h07070, -1, -1);
      tick();
      chan_valid_in = '0;
      drain(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pid_channel_scheduler.md
PID_CHANNEL_SCHEDULER -- requirements
Module: pid_channel_scheduler

Interface
REQ-001 Parameter N_CHAN, default 8: number of input channels sharing one PID core, range 2..16.
REQ-002 Parameter W_DATA, default 18: sample and result width, signed.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: WAIT-state watchdog limit in clocks.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk_in  in  1  system clock.
REQ-006 reset_n_in  in  1  asynchronous active-low reset.
REQ-007 chan_data_in  in  N_CHAN*W_DATA  packed channel samples; channel i occupies bits [i*W_DATA +: W_DATA].
REQ-008 chan_valid_in  in  N_CHAN  per-channel sample strobe.
REQ-009 chan_en_in  in  N_CHAN  per-channel lock enable.
REQ-010 clear_in  in  1  synchronous clear of pending and overrun flags.
REQ-011 core_data_out  out  W_DATA  sample issued to the PID core.
REQ-012 core_chan_out  out  W_CID  channel id issued with the sample.
REQ-013 core_valid_out  out  1  one-cycle issue strobe.
REQ-014 core_data_in  in  W_DATA  PID core result.
REQ-015 core_valid_in  in  1  PID core result strobe.
REQ-016 result_data_out  out  W_DATA  routed result.
REQ-017 result_chan_out  out  W_CID  channel id of the routed result.
REQ-018 result_valid_out  out  1  one-cycle result strobe.
REQ-019 overrun_out  out  N_CHAN  sticky per-channel overrun flags.
REQ-020 timeout_out  out  1  one-cycle watchdog pulse.

Function
REQ-021 Capture: chan_valid_in[i] & chan_en_in[i] SHALL write sample buffer i and set pending[i]. A capture while pending[i]=1 SHALL overwrite the buffer and set overrun[i]. A capture in the same cycle that channel i is issued SHALL set pending[i]=1 and SHALL NOT set overrun[i].
REQ-022 chan_en_in[i]=0 SHALL clear pending[i] and ignore chan_valid_in[i].
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT and ROUTE.
REQ-024 IDLE SHALL transition to ISSUE when any pending bit is set, granting the first pending channel after last_grant in circular ascending order.
REQ-025 ISSUE SHALL last one cycle with core_valid_out=1, core_data_out=buffer[grant] and core_chan_out=grant; it SHALL clear pending[grant], update last_grant and transition to WAIT.
REQ-026 WAIT SHALL transition to ROUTE when core_valid_in=1, latching core_data_in. core_valid_in outside WAIT SHALL be ignored.
REQ-027 ROUTE SHALL last one cycle with result_valid_out=1 and result_chan_out=grant, then transition to IDLE.
REQ-028 Latency: a capture seen by an idle FSM SHALL give core_valid_out two cycles after the capture edge. result_valid_out SHALL follow the core_valid_in sample by one cycle.
REQ-029 Only one transaction SHALL be in flight; new captures during ISSUE, WAIT or ROUTE SHALL only set pending.
REQ-030 clear_in SHALL clear all pending and overrun bits and SHALL NOT abort an in-flight transaction; clear_in SHALL take priority over a simultaneous capture.
REQ-031 W_CID SHALL be max(1, clog2(N_CHAN)).

Reset
REQ-032 reset_n_in=0 SHALL asynchronously force: FSM to IDLE, pending=0, overrun_out=0, last_grant=N_CHAN-1 (channel 0 is granted first), and all data, strobe and id outputs to 0.
REQ-033 Reset during WAIT SHALL discard the transaction; a core_valid_in arriving after reset SHALL be ignored.

Configuration
REQ-034 With macro PID_SCHED_TIMEOUT_EN defined, a WAIT counter starting at 0 SHALL, on reaching TIMEOUT_CYCLES-1 without core_valid_in, pulse timeout_out for one cycle and return the FSM to IDLE with no result. core_valid_in and the limit in the same cycle SHALL resolve as a normal result.
REQ-035 Without PID_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely and timeout_out SHALL be tied to 0.

Structure
REQ-036 Package pid_sched_pkg SHALL hold the FSM state encoding and the W_CID helper function.
REQ-037 Sub-module pid_rr_arbiter SHALL perform the circular priority pick from the pending vector and last_grant.

Verification
REQ-038 Single sample: ch3 captures 0x00100, core echoes after 5 cycles -> core_valid_out at +2 with id 3, result_valid_out with 0x00100 and id 3.
REQ-039 Fairness: all 8 channels pending, core responds in 1 cycle -> grants in order 0..7, then 0 again on a refill.
REQ-040 Overrun: ch1 captures twice while the core is stalled -> overrun_out[1]=1 and the second sample is issued; clear_in -> overrun_out=0.
REQ-041 Same-cycle capture on issue: ch2 captures during its own ISSUE cycle -> pending[2]=1, overrun_out[2]=0, ch2 re-issued next.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=64): core silent -> timeout_out pulses once, FSM returns to IDLE, no result_valid_out; a late core_valid_in is ignored.
REQ-043 Async reset asserted mid-WAIT -> outputs 0 immediately, and the first grant after release is ch0.
